// File: rtl/ser_to_par_load_8.sv
// Serial-to-parallel framer: assembles WIDTH serial bits into Z with a one-cycle LD strobe.
// Optional even-parity bit after the data bits is enabled by defining PARITY_EN.
module ser_to_par_load_8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SVALID,
  input  logic             SIN,
  output logic [WIDTH-1:0] Z,
  output logic             LD,
  output logic             BUSY,
  output logic             ERR
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
`ifdef PARITY_EN
    PAR,
`endif
    DONE
  } state_t;

  state_t             state, state_next;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   sh_next;
  logic [CNT_W-1:0]   cnt;
  logic               clear;
  logic               sample;
  logic               last_bit;
  logic               par_sample;

  assign sh_next  = MSB_FIRST ? {shreg[WIDTH-2:0], SIN} : {SIN, shreg[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign BUSY     = (state == SHIFT)
`ifdef PARITY_EN
                 || (state == PAR)
`endif
                 ;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    sample     = 1'b0;
    par_sample = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          state_next = SHIFT;
          clear      = 1'b1;
        end
      end
      SHIFT: begin
        if (START) begin
          clear = 1'b1;
        end else if (SVALID) begin
          sample = 1'b1;
          if (last_bit) begin
`ifdef PARITY_EN
            state_next = PAR;
`else
            state_next = DONE;
`endif
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (START) begin
          state_next = SHIFT;
          clear      = 1'b1;
        end else if (SVALID) begin
          state_next = DONE;
          par_sample = 1'b1;
        end
      end
`endif
      DONE: begin
        if (START) begin
          state_next = SHIFT;
          clear      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Z and LD are registered on the edge that samples the final bit, so LD and the new
  // byte appear together in the DONE cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg <= '0;
      cnt   <= '0;
      Z     <= '0;
      LD    <= 1'b0;
    end else begin
      LD <= 1'b0;
      if (clear) begin
        shreg <= '0;
        cnt   <= '0;
      end else if (sample) begin
        shreg <= sh_next;
        cnt   <= last_bit ? '0 : cnt + 1'b1;
`ifndef PARITY_EN
        if (last_bit) begin
          Z  <= sh_next;
          LD <= 1'b1;
        end
`endif
      end else if (par_sample) begin
        if (!(^shreg ^ SIN)) begin
          Z  <= shreg;
          LD <= 1'b1;
        end
      end
    end
  end

`ifdef PARITY_EN
  // Error is sticky until the next frame start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              ERR <= 1'b0;
    else if (START)                       ERR <= 1'b0;
    else if (par_sample && (^shreg ^ SIN)) ERR <= 1'b1;
  end
`else
  assign ERR = 1'b0;
`endif

endmodule
